// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: data widths, broadcast record and per-source request record.
package sys_defs;
  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } CDB_DATA;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } CDB_REQ;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports, back-pressure and CDB broadcast bundle.
interface cdb_arbiter_if import sys_defs::*; #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2
) ();
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_SRC-1:0]                  fu_valid;
  logic [NUM_SRC-1:0][XLEN-1:0]        fu_value;
  logic [NUM_SRC-1:0][ROB_TAG_LEN-1:0] fu_rob_tag;
  logic [NUM_SRC-1:0]                  fu_ready;
  CDB_DATA                             cdb_data;
  logic [NUM_SRC-1:0][CW-1:0]          fifo_count;

  modport slave  (input  fu_valid, fu_value, fu_rob_tag,
                  output fu_ready, cdb_data, fifo_count);
  modport master (output fu_valid, fu_value, fu_rob_tag,
                  input  fu_ready, cdb_data, fifo_count);
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; ready is derived from the registered count only.
module cdb_src_fifo import sys_defs::*; #(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  CDB_REQ        push_data_i,
  input  logic          pop_i,
  output CDB_REQ        head_data_o,
  output logic [CW-1:0] count_o,
  output logic          not_full_o
);
  CDB_REQ        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign not_full_o  = (count_q < CW'(DEPTH));
  assign do_push     = push_i && not_full_o;
  assign do_pop      = pop_i && (count_q != '0);
  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: per-unit FIFOs, round-robin grant, registered broadcast.
module cdb_arbiter import sys_defs::*; #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic           clock,
  input logic           reset,
  cdb_arbiter_if.slave  bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  CDB_REQ [NUM_SRC-1:0]          req, head;
  logic   [NUM_SRC-1:0][CW-1:0]  cnt;
  logic   [NUM_SRC-1:0]          not_full, pop;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d, win;
  logic          found;
  int            scan_idx;
  CDB_DATA       cdb_q, cdb_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign req[g] = '{rob_tag: bus.fu_rob_tag[g], value: bus.fu_value[g]};

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (bus.fu_valid[g]),
      .push_data_i (req[g]),
      .pop_i       (pop[g]),
      .head_data_o (head[g]),
      .count_o     (cnt[g]),
      .not_full_o  (not_full[g])
    );
  end

  assign bus.fu_ready   = not_full;
  assign bus.fifo_count = cnt;
  assign bus.cdb_data   = cdb_q;

  // First non-empty source scanning upward from rr_ptr.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    pop      = '0;
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!found && cnt[scan_idx] != '0) begin
        found = 1'b1;
        win   = IW'(scan_idx);
      end
    end
    if (found) begin
      pop[win] = 1'b1;
      cdb_d    = '{valid: TRUE, rob_tag: head[win].rob_tag, value: head[win].value};
      rr_ptr_d = (win == IW'(NUM_SRC - 1)) ? '0 : win + IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
